// File: rtl/alu_tr_vote_if.sv
// Operand request / voted result bundle for the time-redundant ALU.
interface alu_tr_vote_if #(
    parameter int WIDTH     = 32,
    parameter int MAX_RETRY = 2,
    parameter int CNT_W     = 16
);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       alu_ctrl;
    logic [2:0]       inj_sel;
    logic [WIDTH-1:0] inj_mask;
    logic             inj_persist;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             negative;
    logic             carry;
    logic             overflow;
    logic             fault_detected;
    logic             fault_corrected;
    logic             fault_uncorrectable;
    logic [RW-1:0]    retries;
    logic             cnt_clr;
    logic [CNT_W-1:0] fault_count;

    modport master (
        output in_valid, a, b, alu_ctrl, inj_sel, inj_mask, inj_persist, out_ready, cnt_clr,
        input  in_ready, out_valid, result, zero, negative, carry, overflow,
               fault_detected, fault_corrected, fault_uncorrectable, retries, fault_count
    );

    modport slave (
        input  in_valid, a, b, alu_ctrl, inj_sel, inj_mask, inj_persist, out_ready, cnt_clr,
        output in_ready, out_valid, result, zero, negative, carry, overflow,
               fault_detected, fault_corrected, fault_uncorrectable, retries, fault_count
    );
endinterface

// File: rtl/alu_tr_vote.sv
// Time-redundant ALU: each op runs 2-3 times on one datapath, results are
// majority-voted, and a three-way disagreement re-runs the whole op.
//
//  state | meaning
//  IDLE  | waiting for an operand request (in_ready=1)
//  EX1   | first execution, sample captured into s1
//  EX2   | second execution, compared against s1
//  EX3   | tie-break execution, voted against s1/s2
//  DONE  | voted result presented until out_ready
module alu_tr_vote #(
    parameter int WIDTH     = 32,
    parameter int MAX_RETRY = 2,
    parameter int CNT_W     = 16
) (
    input logic         clk,
    input logic         rst,
    alu_tr_vote_if.slave bus
);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int SW = WIDTH + 2;

    typedef enum logic [2:0] {IDLE, EX1, EX2, EX3, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_q, b_q, mask_q, result_q;
    logic [2:0]       ctrl_q, sel_q;
    logic             persist_q, carry_q, overflow_q;
    logic             det_q, corr_q, unc_q;
    logic [RW-1:0]    retries_q;
    logic [CNT_W-1:0] count_q;
    logic [SW-1:0]    s1_q, s2_q, sample;

    logic accept, cap_s1, cap_s2, load_out, set_det, set_corr, set_unc, inc_retry;

    logic [WIDTH-1:0] b_op, alu_r, rot;
    logic [WIDTH:0]   sum_full;
    logic             alu_c, alu_o, inj_on;

    // Shared ALU plus the per-execution corruption pattern.
    always_comb begin
        b_op     = (ctrl_q == 3'b001) ? ~b_q : b_q;
        sum_full = {1'b0, a_q} + {1'b0, b_op} + {{WIDTH{1'b0}}, (ctrl_q == 3'b001)};
        alu_r    = '0;
        alu_c    = 1'b0;
        alu_o    = 1'b0;
        case (ctrl_q)
            3'b000, 3'b001: begin
                alu_r = sum_full[WIDTH-1:0];
                alu_c = sum_full[WIDTH];
                alu_o = (a_q[WIDTH-1] == b_op[WIDTH-1]) && (sum_full[WIDTH-1] != a_q[WIDTH-1]);
            end
            3'b010:  alu_r = a_q & b_q;
            3'b011:  alu_r = a_q | b_q;
            3'b101:  alu_r = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            default: alu_r = '0;
        endcase
        rot    = mask_q;
        inj_on = 1'b0;
        case (state)
            EX1: inj_on = sel_q[0];
            EX2: begin
                inj_on = sel_q[1];
                rot    = {mask_q[WIDTH-2:0], mask_q[WIDTH-1]};
            end
            EX3: begin
                inj_on = sel_q[2];
                rot    = {mask_q[WIDTH-3:0], mask_q[WIDTH-1:WIDTH-2]};
            end
            default: inj_on = 1'b0;
        endcase
        inj_on = inj_on && ((retries_q == '0) || persist_q);
        sample = {alu_c, alu_o, alu_r ^ (inj_on ? rot : '0)};
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Next-state decode and datapath strobes.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        cap_s1     = 1'b0;
        cap_s2     = 1'b0;
        load_out   = 1'b0;
        set_det    = 1'b0;
        set_corr   = 1'b0;
        set_unc    = 1'b0;
        inc_retry  = 1'b0;
        case (state)
            IDLE: if (bus.in_valid) begin
                accept     = 1'b1;
                state_next = EX1;
            end
            EX1: begin
                cap_s1     = 1'b1;
                state_next = EX2;
            end
            EX2: if (sample == s1_q) begin
                load_out   = 1'b1;
                state_next = DONE;
            end else begin
                cap_s2     = 1'b1;
                set_det    = 1'b1;
                state_next = EX3;
            end
            EX3: if (sample == s1_q || sample == s2_q) begin
                load_out   = 1'b1;
                set_corr   = 1'b1;
                state_next = DONE;
            end else if (int'(retries_q) < MAX_RETRY) begin
                inc_retry  = 1'b1;
                state_next = EX1;
            end else begin
                load_out   = 1'b1;
                set_unc    = 1'b1;
                state_next = DONE;
            end
            DONE: if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand latch, samples, voted outputs, status flags and the fault counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q        <= '0;
            b_q        <= '0;
            mask_q     <= '0;
            ctrl_q     <= '0;
            sel_q      <= '0;
            persist_q  <= 1'b0;
            s1_q       <= '0;
            s2_q       <= '0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            det_q      <= 1'b0;
            corr_q     <= 1'b0;
            unc_q      <= 1'b0;
            retries_q  <= '0;
            count_q    <= '0;
        end else begin
            if (accept) begin
                a_q        <= bus.a;
                b_q        <= bus.b;
                ctrl_q     <= bus.alu_ctrl;
                sel_q      <= bus.inj_sel;
                mask_q     <= bus.inj_mask;
                persist_q  <= bus.inj_persist;
                retries_q  <= '0;
                carry_q    <= 1'b0;
                overflow_q <= 1'b0;
                det_q      <= 1'b0;
                corr_q     <= 1'b0;
                unc_q      <= 1'b0;
            end
            if (cap_s1)    s1_q <= sample;
            if (cap_s2)    s2_q <= sample;
            if (set_det)   det_q <= 1'b1;
            if (set_corr)  corr_q <= 1'b1;
            if (set_unc)   unc_q <= 1'b1;
            if (inc_retry) retries_q <= retries_q + 1'b1;
            if (load_out) begin
                result_q   <= sample[WIDTH-1:0];
                overflow_q <= sample[WIDTH];
                carry_q    <= sample[WIDTH+1];
            end
            // det_q is already set on every path into DONE that saw a mismatch
            if (bus.cnt_clr)
                count_q <= '0;
            else if (load_out && det_q && count_q != '1)
                count_q <= count_q + 1'b1;
        end
    end

    assign bus.in_ready            = (state == IDLE);
    assign bus.out_valid           = (state == DONE);
    assign bus.result              = result_q;
    assign bus.zero                = (state == DONE) && (result_q == '0);
    assign bus.negative            = (state == DONE) && result_q[WIDTH-1];
    assign bus.carry               = carry_q;
    assign bus.overflow            = overflow_q;
    assign bus.fault_detected      = det_q;
    assign bus.fault_corrected     = corr_q;
    assign bus.fault_uncorrectable = unc_q;
    assign bus.retries             = retries_q;
    assign bus.fault_count         = count_q;
endmodule

// File: tb/tb_alu_tr_vote.sv
// Directed and random operations against a behavioural vote/retry model.
module tb_alu_tr_vote;
    localparam int W  = 32;
    localparam int MR = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   model_count = 0;

    alu_tr_vote_if #(.WIDTH(W), .MAX_RETRY(MR), .CNT_W(16)) bus();

    alu_tr_vote #(.WIDTH(W), .MAX_RETRY(MR), .CNT_W(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] m, input int n);
        logic [63:0] t;
        t = {m, m} << n;
        return t[63:32];
    endfunction

    // Golden {carry, overflow, result} from plain integer arithmetic.
    function automatic logic [33:0] golden(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        longint sa, sb, sr;
        logic [31:0] r;
        logic c, o;
        sa = $signed(a);
        sb = $signed(b);
        r = 0; c = 0; o = 0;
        case (op)
            3'd0: begin
                r  = a + b;
                c  = ({32'd0, a} + {32'd0, b}) > 64'hFFFF_FFFF;
                sr = sa + sb;
                o  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            3'd1: begin
                r  = a - b;
                c  = (a >= b);
                sr = sa - sb;
                o  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd5: r = (sa < sb) ? 32'd1 : 32'd0;
            default: r = 0;
        endcase
        return {c, o, r};
    endfunction

    task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op, input logic [2:0] sel, input logic [31:0] mask,
                          input logic persist, input int hold, input logic clr);
        logic [33:0] tv, s[3], outv;
        int retry, exp_lat, lat;
        logic det, corr, unc, fin;
        tv = golden(a, b, op);
        retry = 0; exp_lat = 0; det = 0; corr = 0; unc = 0; fin = 0; outv = 0;
        while (!fin) begin
            for (int k = 0; k < 3; k++) begin
                s[k] = tv;
                if (sel[k] && (retry == 0 || persist)) s[k][31:0] = tv[31:0] ^ rotl(mask, k);
            end
            if (s[0] == s[1]) begin
                exp_lat += 2; outv = s[1]; fin = 1;
            end else begin
                det = 1; exp_lat += 3;
                if (s[2] == s[0] || s[2] == s[1]) begin
                    corr = 1; outv = s[2]; fin = 1;
                end else if (retry < MR) begin
                    retry++;
                end else begin
                    unc = 1; outv = s[2]; fin = 1;
                end
            end
        end
        if (clr) model_count = 0;
        else if (det && model_count < 65535) model_count++;

        @(negedge clk);
        bus.a = a; bus.b = b; bus.alu_ctrl = op; bus.inj_sel = sel;
        bus.inj_mask = mask; bus.inj_persist = persist; bus.in_valid = 1'b1;
        bus.cnt_clr = clr;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a = $urandom; bus.b = $urandom; bus.inj_sel = 3'($urandom);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!bus.out_valid && lat < 40);
        if (!bus.out_valid) begin
            check({nm, " timeout"}, 0, 1);
        end else begin
            check({nm, " latency"}, lat, exp_lat);
            check({nm, " result"}, bus.result, outv[31:0]);
            check({nm, " overflow"}, bus.overflow, outv[32]);
            check({nm, " carry"}, bus.carry, outv[33]);
            check({nm, " zero"}, bus.zero, outv[31:0] == 0);
            check({nm, " negative"}, bus.negative, outv[31]);
            check({nm, " detected"}, bus.fault_detected, det);
            check({nm, " corrected"}, bus.fault_corrected, corr);
            check({nm, " uncorrectable"}, bus.fault_uncorrectable, unc);
            check({nm, " retries"}, bus.retries, retry);
            check({nm, " fault_count"}, bus.fault_count, model_count);
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check({nm, " hold valid"}, bus.out_valid, 1);
                check({nm, " hold in_ready"}, bus.in_ready, 0);
                check({nm, " hold result"}, bus.result, outv[31:0]);
            end
            bus.cnt_clr = 1'b0;
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.out_ready = 1'b0;
            @(negedge clk);
            check({nm, " back to idle"}, {bus.in_ready, bus.out_valid}, 2'b10);
        end
        bus.cnt_clr = 1'b0;
    endtask

    initial begin
        int lat;
        bus.in_valid = 0; bus.a = 0; bus.b = 0; bus.alu_ctrl = 0; bus.inj_sel = 0;
        bus.inj_mask = 0; bus.inj_persist = 0; bus.out_ready = 0; bus.cnt_clr = 0;
        repeat (3) @(negedge clk);
        check("reset out_valid", bus.out_valid, 0);
        check("reset result", bus.result, 0);
        check("reset zero", bus.zero, 0);
        check("reset fault_count", bus.fault_count, 0);
        rst = 1'b1;
        @(negedge clk);
        check("reset in_ready", bus.in_ready, 1);
        check("reset retries", bus.retries, 0);

        run_op("T1", 5, 3, 3'd0, 3'b000, 0, 0, 0, 0);
        run_op("T2", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 3'd1, 3'b000, 0, 0, 0, 0);
        run_op("T3", 1, 1, 3'd0, 3'b001, 32'h10, 0, 0, 0);
        run_op("T4", 32'hF0F0_1234, 32'h0FF0_FFFF, 3'd2, 3'b111, 1, 1, 0, 0);
        run_op("T5", 32'h1234_5678, 32'h0000_1111, 3'd0, 3'b111, 1, 0, 10, 0);
        run_op("SLT", 32'hFFFF_FFFE, 32'h1, 3'd5, 3'b010, 32'h8000_0001, 0, 1, 0);
        run_op("OR", 32'h8000_0000, 32'h1, 3'd3, 3'b100, 32'h3, 1, 0, 0);
        run_op("CLR", 7, 9, 3'd1, 3'b011, 32'h55, 0, 0, 1);
        for (int i = 0; i < 40; i++)
            run_op("RND", $urandom, $urandom, 3'($urandom), 3'($urandom),
                   ($urandom_range(0, 3) == 0) ? 32'h1 << $urandom_range(0, 31) : $urandom,
                   1'($urandom), $urandom_range(0, 2), ($urandom_range(0, 7) == 0));

        // T6: reset in the tie-break execution aborts the op and the counter
        @(negedge clk);
        bus.a = 1; bus.b = 1; bus.alu_ctrl = 0; bus.inj_sel = 3'b001;
        bus.inj_mask = 32'h10; bus.inj_persist = 0; bus.in_valid = 1;
        @(posedge clk);
        #1 bus.in_valid = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("T6 out_valid", bus.out_valid, 0);
        check("T6 fault_count", bus.fault_count, 0);
        model_count = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("T6 in_ready", bus.in_ready, 1);
        lat = 0;
        run_op("T6 clean", 32'd100, 32'd58, 3'd1, 3'b000, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
